pwm_motor_ctrl: RTL and testbench

//  Parametrised N-channel H-bridge motor controller for the Nano car; successor to the fixed 2-motor switch-driven core.
//  Per channel: registered PWM enable plus IN1/IN2 direction pins (enableA/B, JA1..JA4 on the board).

---
 rtl/pwm_motor_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pwm_motor_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_motor_ctrl.sv
// N-channel H-bridge controller: shared PWM timebase, per-channel soft-start ramp,
// safe reversal (ramp-down then dead time) and short-brake.
//  state        | meaning
//  ST_DRIVE     | pins follow dir_cur, duty ramps toward duty_cmd on each period boundary
//  ST_RAMP_DOWN | reversal pending, duty ramps to 0 with pins held
//  ST_DEAD      | bridge fully off for DEAD_PERIODS period boundaries
//  ST_BRAKE     | both bridge inputs and enable high (short-brake)
module pwm_motor_ctrl #(
    parameter int N_CH         = 2,
    parameter int DUTY_W       = 4,
    parameter int PRESC        = 390,
    parameter int RAMP_STEP    = 1,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_CH*DUTY_W-1:0]   duty_cmd,
    input  logic [N_CH-1:0]          dir_cmd,
    input  logic [N_CH-1:0]          brake,
    output logic [N_CH-1:0]          pwm_en,
    output logic [N_CH-1:0]          in_a,
    output logic [N_CH-1:0]          in_b,
    output logic [N_CH-1:0]          busy
);

    localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC - 1);
    localparam logic [DUTY_W-1:0] TC_LAST    = DUTY_W'((1 << DUTY_W) - 2);
    localparam logic [DCW-1:0]    DEAD_LAST  = DCW'(DEAD_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_DRIVE     = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_DEAD      = 2'd2,
        ST_BRAKE     = 2'd3
    } state_t;

    logic [PW-1:0]     r_presc;
    logic [DUTY_W-1:0] r_tcnt;
    logic              w_tick;
    logic              w_pb;

    state_t            r_state     [N_CH];
    state_t            w_nxt_state [N_CH];
    logic [DUTY_W-1:0] r_duty      [N_CH];
    logic [DUTY_W-1:0] w_nxt_duty  [N_CH];
    logic [DCW-1:0]    r_dcnt      [N_CH];
    logic [DCW-1:0]    w_nxt_dcnt  [N_CH];
    logic [N_CH-1:0]   r_dir;
    logic [N_CH-1:0]   w_nxt_dir;

    logic [N_CH-1:0]   r_pwm;
    logic [N_CH-1:0]   r_in_a;
    logic [N_CH-1:0]   r_in_b;
    logic [N_CH-1:0]   r_busy;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_pb   = w_tick && (r_tcnt == TC_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_tcnt  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_tcnt <= (r_tcnt == TC_LAST) ? '0 : r_tcnt + DUTY_W'(1);
            end
        end
    end

    // Saturating step: never passes the target, never wraps.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        int c;
        int t;
        c = int'(cur);
        t = int'(tgt);
        if (c < t) begin
            return (t - c > RAMP_STEP) ? DUTY_W'(c + RAMP_STEP) : tgt;
        end else if (c > t) begin
            return (c - t > RAMP_STEP) ? DUTY_W'(c - RAMP_STEP) : tgt;
        end
        return cur;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_nxt_state[i] = r_state[i];
            w_nxt_duty[i]  = r_duty[i];
            w_nxt_dcnt[i]  = r_dcnt[i];
            w_nxt_dir[i]   = r_dir[i];
            if (brake[i]) begin
                w_nxt_state[i] = ST_BRAKE;
                w_nxt_duty[i]  = '0;
                w_nxt_dcnt[i]  = '0;
            end else begin
                case (r_state[i])
                    ST_DRIVE: begin
                        if (dir_cmd[i] != r_dir[i]) begin
                            if (r_duty[i] != '0) begin
                                w_nxt_state[i] = ST_RAMP_DOWN;
                            end else begin
                                w_nxt_state[i] = ST_DEAD;
                                w_nxt_dcnt[i]  = '0;
                            end
                        end else if (w_pb) begin
                            w_nxt_duty[i] = step_toward(r_duty[i], duty_cmd[i*DUTY_W +: DUTY_W]);
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (dir_cmd[i] == r_dir[i]) begin
                            w_nxt_state[i] = ST_DRIVE;
                        end else if (r_duty[i] == '0) begin
                            w_nxt_state[i] = ST_DEAD;
                            w_nxt_dcnt[i]  = '0;
                        end else if (w_pb) begin
                            w_nxt_duty[i] = step_toward(r_duty[i], '0);
                        end
                    end
                    ST_DEAD: begin
                        if (w_pb) begin
                            if (r_dcnt[i] == DEAD_LAST) begin
                                w_nxt_state[i] = ST_DRIVE;
                                w_nxt_dir[i]   = dir_cmd[i];
                                w_nxt_duty[i]  = '0;
                                w_nxt_dcnt[i]  = '0;
                            end else begin
                                w_nxt_dcnt[i] = r_dcnt[i] + DCW'(1);
                            end
                        end
                    end
                    ST_BRAKE: begin
                        w_nxt_state[i] = ST_DEAD;
                        w_nxt_dcnt[i]  = '0;
                    end
                    default: w_nxt_state[i] = ST_DRIVE;
                endcase
            end
        end
    end

    // Outputs decode from the next state so pins and enable switch on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_DRIVE;
                r_duty[i]  <= '0;
                r_dcnt[i]  <= '0;
            end
            r_dir  <= '0;
            r_pwm  <= '0;
            r_in_a <= '0;
            r_in_b <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_nxt_state[i];
                r_duty[i]  <= w_nxt_duty[i];
                r_dcnt[i]  <= w_nxt_dcnt[i];
                r_dir[i]   <= w_nxt_dir[i];
                case (w_nxt_state[i])
                    ST_DRIVE, ST_RAMP_DOWN: begin
                        r_pwm[i]  <= (r_tcnt < r_duty[i]);
                        r_in_a[i] <= w_nxt_dir[i];
                        r_in_b[i] <= ~w_nxt_dir[i];
                        r_busy[i] <= (w_nxt_state[i] == ST_RAMP_DOWN);
                    end
                    ST_BRAKE: begin
                        r_pwm[i]  <= 1'b1;
                        r_in_a[i] <= 1'b1;
                        r_in_b[i] <= 1'b1;
                        r_busy[i] <= 1'b0;
                    end
                    default: begin
                        r_pwm[i]  <= 1'b0;
                        r_in_a[i] <= 1'b0;
                        r_in_b[i] <= 1'b0;
                        r_busy[i] <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pwm_en = r_pwm;
    assign in_a   = r_in_a;
    assign in_b   = r_in_b;
    assign busy   = r_busy;

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Scoreboard bench: a per-PWM-period model predicts high-cycle count, pins and busy for
// every channel; a monitor integrates the DUT outputs over each period and compares.
module tb_pwm_motor_ctrl;

    localparam int N_CH         = 3;
    localparam int DUTY_W       = 4;
    localparam int PRESC        = 2;
    localparam int RAMP_STEP    = 3;
    localparam int DEAD_PERIODS = 2;
    localparam int L            = (1 << DUTY_W) - 1;
    localparam int LP           = L * PRESC;

    localparam int M_DRV  = 0;
    localparam int M_RD   = 1;
    localparam int M_DEAD = 2;
    localparam int M_BRK  = 3;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_CH*DUTY_W-1:0] duty_cmd = '0;
    logic [N_CH-1:0]        dir_cmd = '0;
    logic [N_CH-1:0]        brake = '0;
    logic [N_CH-1:0]        pwm_en;
    logic [N_CH-1:0]        in_a;
    logic [N_CH-1:0]        in_b;
    logic [N_CH-1:0]        busy;

    always #5 clock = ~clock;

    pwm_motor_ctrl #(
        .N_CH(N_CH), .DUTY_W(DUTY_W), .PRESC(PRESC),
        .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .duty_cmd(duty_cmd), .dir_cmd(dir_cmd),
        .brake(brake), .pwm_en(pwm_en), .in_a(in_a), .in_b(in_b), .busy(busy)
    );

    typedef struct packed {
        logic [15:0]       win;
        logic [N_CH-1:0]   a;
        logic [N_CH-1:0]   b;
        logic [N_CH-1:0]   bsy;
        logic [N_CH*8-1:0] high;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   win_base = 0;

    int   m_mode [N_CH];
    int   m_duty [N_CH];
    int   m_dir  [N_CH];
    int   m_dl   [N_CH];
    int   s_cmd  [N_CH];
    bit   s_dir  [N_CH];

    task automatic check(input string name, input int win, input int ch, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s win=%0d ch=%0d actual=%0d required=%0d", name, win, ch, act, req);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = M_DRV;
            m_duty[c] = 0;
            m_dir[c]  = 0;
            m_dl[c]   = 0;
        end
    endtask

    // Inputs change only at period starts, so every input-driven transition lands on the
    // first edge of a period and the whole period shows the new mode.
    task automatic model_start(input int c, input bit br, input bit d,
                               output int hi, output bit a, output bit b, output bit bsy);
        if (br) begin
            m_mode[c] = M_BRK;
            m_duty[c] = 0;
        end else begin
            case (m_mode[c])
                M_DRV: if (int'(d) != m_dir[c]) begin
                    if (m_duty[c] > 0) m_mode[c] = M_RD;
                    else begin m_mode[c] = M_DEAD; m_dl[c] = DEAD_PERIODS; end
                end
                M_RD: if (int'(d) == m_dir[c]) m_mode[c] = M_DRV;
                      else if (m_duty[c] == 0) begin m_mode[c] = M_DEAD; m_dl[c] = DEAD_PERIODS; end
                M_BRK: begin m_mode[c] = M_DEAD; m_dl[c] = DEAD_PERIODS; end
                default: ;
            endcase
        end
        case (m_mode[c])
            M_DRV, M_RD: begin
                hi = m_duty[c] * PRESC; a = (m_dir[c] != 0); b = (m_dir[c] == 0); bsy = (m_mode[c] == M_RD);
            end
            M_BRK:   begin hi = LP; a = 1; b = 1; bsy = 0; end
            default: begin hi = 0;  a = 0; b = 0; bsy = 1; end
        endcase
    endtask

    task automatic model_end(input int c, input int cmd, input bit d);
        case (m_mode[c])
            M_DRV: begin
                if (m_duty[c] < cmd)      m_duty[c] = (m_duty[c] + RAMP_STEP < cmd) ? m_duty[c] + RAMP_STEP : cmd;
                else if (m_duty[c] > cmd) m_duty[c] = (m_duty[c] - RAMP_STEP > cmd) ? m_duty[c] - RAMP_STEP : cmd;
            end
            M_RD: m_duty[c] = (m_duty[c] > RAMP_STEP) ? m_duty[c] - RAMP_STEP : 0;
            M_DEAD: begin
                m_dl[c]--;
                if (m_dl[c] == 0) begin m_mode[c] = M_DRV; m_dir[c] = int'(d); m_duty[c] = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic pick(input int kind, input int w, input int c, output int cmd, output bit d, output bit br);
        br = 0; d = 1; cmd = 0;
        case (kind)
            0: begin
                if (c == 0) begin
                    if (w < 14)      begin d = 1; cmd = 8; end
                    else if (w < 30) begin d = 0; cmd = 8; end
                    else if (w < 33) begin d = 0; cmd = 8; br = 1; end
                    else             begin d = 1; cmd = 6; end
                end else if (c == 1) begin
                    cmd = (w < 20) ? L : 0;
                end else begin
                    cmd = 5;
                end
            end
            1: begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0: s_cmd[c] = 0;
                        1: s_cmd[c] = L;
                        default: s_cmd[c] = int'($urandom_range(1, L - 1));
                    endcase
                end
                if ($urandom_range(0, 7) == 0) s_dir[c] = !s_dir[c];
                br  = ($urandom_range(0, 11) == 0);
                cmd = s_cmd[c];
                d   = s_dir[c];
            end
            default: begin cmd = L; d = 1; end
        endcase
    endtask

    task automatic run_phase(input int kind, input int nwin);
        fork
            begin
                int cur_cmd [N_CH];
                bit cur_d   [N_CH];
                for (int w = 0; w < nwin; w++) begin
                    exp_t e;
                    e = '0;
                    e.win = 16'(win_base + w);
                    for (int c = 0; c < N_CH; c++) begin
                        int hi;
                        bit br, a, b, bsy;
                        pick(kind, w, c, cur_cmd[c], cur_d[c], br);
                        duty_cmd[c*DUTY_W +: DUTY_W] = DUTY_W'(cur_cmd[c]);
                        dir_cmd[c] = cur_d[c];
                        brake[c]   = br;
                        model_start(c, br, cur_d[c], hi, a, b, bsy);
                        e.high[c*8 +: 8] = 8'(hi);
                        e.a[c] = a; e.b[c] = b; e.bsy[c] = bsy;
                    end
                    sb_q.push_back(e);
                    repeat (LP) @(posedge clock);
                    for (int c = 0; c < N_CH; c++) model_end(c, cur_cmd[c], cur_d[c]);
                    @(negedge clock);
                end
            end
            begin
                for (int w = 0; w < nwin; w++) begin
                    int              hi [N_CH];
                    logic [N_CH-1:0] sa, sb, sbsy;
                    exp_t            e;
                    sa = '0; sb = '0; sbsy = '0;
                    for (int c = 0; c < N_CH; c++) hi[c] = 0;
                    for (int i = 1; i <= LP; i++) begin
                        @(posedge clock);
                        @(negedge clock);
                        for (int c = 0; c < N_CH; c++) hi[c] += int'(pwm_en[c]);
                        if (i == LP / 2) begin sa = in_a; sb = in_b; sbsy = busy; end
                    end
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL scoreboard_empty win=%0d actual=0 required=1", win_base + w);
                    end else begin
                        e = sb_q.pop_front();
                        for (int c = 0; c < N_CH; c++) begin
                            check("high_ticks", int'(e.win), c, hi[c], int'(e.high[c*8 +: 8]));
                            check("in_a", int'(e.win), c, int'(sa[c]), int'(e.a[c]));
                            check("in_b", int'(e.win), c, int'(sb[c]), int'(e.b[c]));
                            check("busy", int'(e.win), c, int'(sbsy[c]), int'(e.bsy[c]));
                        end
                    end
                end
            end
        join
        win_base += nwin;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        for (int c = 0; c < N_CH; c++) begin s_cmd[c] = 0; s_dir[c] = 0; end
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_pwm_en", -1, -1, int'(pwm_en), 0);
        check("reset_in_a",   -1, -1, int'(in_a), 0);
        check("reset_in_b",   -1, -1, int'(in_b), 0);
        check("reset_busy",   -1, -1, int'(busy), 0);
        reset_n = 1'b1;

        run_phase(0, 45);
        run_phase(1, 100);
        run_phase(2, 18);

        #2;
        for (int c = 0; c < N_CH; c++)
            check("pre_reset_pwm_full", win_base, c, int'(pwm_en[c]),
                  (m_mode[c] == M_DRV && m_duty[c] == L) ? 1 : 0);
        reset_n = 1'b0;
        #1;
        check("async_reset_pwm_en", win_base, -1, int'(pwm_en), 0);
        check("async_reset_in_a",   win_base, -1, int'(in_a), 0);
        check("async_reset_in_b",   win_base, -1, int'(in_b), 0);
        check("async_reset_busy",   win_base, -1, int'(busy), 0);
        repeat (2) @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        run_phase(1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
